tape_sdram_arbiter: RTL
=======================

# tape_sdram_arbiter

Shares the single byte-wide SDRAM port between two requesters: the ioctl loader writing cassette image bytes and the cassette player reading them back. It sits between the loader/cassette logic and the `sdram` controller, replacing a plain address mux. Loader writes are buffered in a small FIFO so they are never lost when they collide with player reads. Reads are served one at a time with a starvation guard, and a watchdog recovers the port if the controller never acknowledges an access.

## Interface
Parameters:
- `AW`, 25, address width
- `FIFO_DEPTH`, 4, loader write buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, cycles a pending read may wait before it beats queued writes
- `TIMEOUT`, 64, cycles to wait for `mem_ack` before the access is abandoned

Ports:
- `clk` in 1: system clock (clk_sys)
- `reset` in 1: asynchronous, active-low reset
- `wr_req` in 1: one-cycle strobe, loader byte valid
- `wr_addr` in AW: loader byte address
- `wr_data` in 8: loader byte
- `wr_full` out 1: FIFO full (status only; the loader cannot stall)
- `rd_req` in 1: one-cycle strobe from the cassette player
- `rd_addr` in AW: player read address
- `rd_busy` out 1: a read is pending or in flight
- `rd_data` out 8: returned byte, held until the next read completes
- `rd_valid` out 1: one-cycle pulse, `rd_data` updated
- `mem_addr` out AW: address to the controller
- `mem_din` out 8: write data to the controller
- `mem_we` out 1: one-cycle write strobe
- `mem_rd` out 1: one-cycle read strobe
- `mem_dout` in 8: read data, valid with `mem_ack`
- `mem_ack` in 1: one-cycle access-complete pulse
- `clear` in 1: synchronous clear of the sticky flags
- `overflow` out 1: sticky; a write was dropped
- `timeout_err` out 1: sticky; the watchdog fired

## Operation
- **FSM states:** IDLE, WRITE, READ.
- **Reset values:** all outputs are 0; the FIFO is empty; no read is pending.

Write path:
- `wr_req` pushes {addr, data} into the FIFO.
- If the FIFO is full and no pop happens in the same cycle, the push is dropped and `overflow` is set.
- A push and a pop in the same cycle while the FIFO is full is accepted; the count is unchanged.

Read path:
- `rd_req` while `rd_busy`=0 latches `rd_addr` and sets the pending flag.
- `rd_req` while `rd_busy`=1 is ignored.

Arbitration in IDLE, evaluated each cycle:
- If a read is pending and its wait counter is ≥ `STARVE_LIMIT`, go to READ.
- Otherwise, if the FIFO is not empty, pop the head and go to WRITE.
- Otherwise, if a read is pending, go to READ.
- The wait counter increments every cycle a read is pending and not granted. It saturates and is cleared on grant.

Access sequencing:
- On entry to WRITE or READ, `mem_addr`/`mem_din` are loaded and `mem_we` or `mem_rd` is pulsed for exactly one cycle.
- The block then waits for `mem_ack`.
- In READ, `mem_ack` latches `mem_dout` into `rd_data`, pulses `rd_valid`, clears the pending flag and returns to IDLE.
- In WRITE, `mem_ack` returns to IDLE.

Watchdog:
- The watchdog counter runs in WRITE and READ.
- On reaching `TIMEOUT`, the FSM returns to IDLE and sets `timeout_err`.
- A timed-out write is discarded.
- A timed-out read clears pending; `rd_valid` is not pulsed and `rd_data` is unchanged.

Other rules:
- `mem_ack` received in IDLE is ignored.
- `clear` clears `overflow` and `timeout_err`. A set event in the same cycle as `clear` wins.
- Asserting `reset` mid-access drops everything and forces the strobes low immediately.

## Timing
- **Strobes:** all outputs are registered.
- **Write latency:** a `wr_req` sampled at edge k into an empty FIFO while the FSM is idle causes the grant at edge k+1 and `mem_we` high during cycle k+1..k+2.
- **Read latency:** a `rd_req` at edge k with nothing queued gives `mem_rd` high during cycle k+1..k+2. A `mem_ack` at edge j gives `rd_valid`/`rd_data` visible after edge j and `rd_busy` low after edge j.
- **Back-to-back:** at least one IDLE cycle separates accesses, so the minimum issue interval is ack + 1 cycle.
- **Counter widths:** the FIFO count is $clog2(FIFO_DEPTH)+1 bits. The wait and watchdog counters are $clog2(limit)+1 bits and saturating.

## Structure
- **Shared package `tape_sdram_pkg`:** the state enum `arb_state_t` {IDLE, WRITE, READ} and the default constants `TAPE_AW`, `TAPE_FIFO_DEPTH`.
- **Sub-module `byte_wr_fifo`:** a synchronous FIFO of {AW+8} bits with push, pop, full, empty, same-cycle push/pop, and asynchronous active-low reset. The arbiter instantiates it once.

## Test plan
- **Single write:** `wr_req` addr 0x000010 data 0xA5 → one `mem_we` pulse with `mem_addr`=0x10, `mem_din`=0xA5; the FIFO is empty afterward.
- **Read round trip:** `rd_req` addr 0x20, controller acks 3 cycles later with 0x5A → `rd_valid` pulses once, `rd_data`=0x5A, `rd_busy` falls the same cycle.
- **Starvation:** keep the FIFO non-empty with a continuous write stream while a read is pending, controller acking at 2-cycle latency → the read is granted after the wait counter reaches 8, then writes resume in order.
- **Overflow:** with acks withheld, 6 consecutive `wr_req` → 4 queued (the first is popped into WRITE), so exactly one is dropped; `overflow`=1, `clear` resets it.
- **Timeout:** `rd_req` with no `mem_ack` → return to IDLE after 64 cycles, `timeout_err`=1, no `rd_valid`, next `rd_req` accepted.
- **Mid-access reset:** assert `reset` low one cycle after `mem_rd` → all outputs 0 and the FIFO empty; after release a late `mem_ack` is ignored.

Source files
------------

// File: rtl/tape_sdram_arbiter_pkg.sv
// Shared types and defaults for the cassette-image SDRAM arbiter.
//   arb_state_t      : arbiter FSM state (IDLE / WRITE / READ)
//   TAPE_AW          : default SDRAM byte-address width
//   TAPE_FIFO_DEPTH  : default depth of the loader write buffer
package tape_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_t;

  localparam int TAPE_AW         = 25;
  localparam int TAPE_FIFO_DEPTH = 4;

endpackage

// File: rtl/tape_sdram_arbiter_byte_wr_fifo.sv
// Small synchronous FIFO buffering loader {addr, data} writes.
//   clk, reset (async, active-low)
//   push/din   : enqueue; accepted when not full, or when full with a pop in the same cycle
//   pop/dout   : dequeue; dout always shows the head entry (first-word fall-through)
//   full/empty : registered status flags
module byte_wr_fifo
  import tape_sdram_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = TAPE_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Accept decisions and next occupancy; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + CW'(1'b1);
      2'b01:   count_s = count_r - CW'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // Entry storage; contents only matter behind valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      count_r <= count_s;
      full    <= (count_s == CW'(DEPTH));
      empty   <= (count_s == {CW{1'b0}});
    end
  end

  assign dout = mem_r[rd_ptr_r];

endmodule

// File: rtl/tape_sdram_arbiter.sv
// Arbitrates the byte-wide SDRAM port between the ioctl loader (buffered writes)
// and the cassette player (single outstanding read), with a read starvation
// guard and an access watchdog.
//   clk, reset (async, active-low), clear (sync clear of sticky flags)
//   wr_req/wr_addr/wr_data, wr_full        : loader side
//   rd_req/rd_addr, rd_busy/rd_data/rd_valid: player side
//   mem_addr/mem_din/mem_we/mem_rd, mem_dout/mem_ack : controller side
//   overflow, timeout_err                  : sticky error flags
module tape_sdram_arbiter
  import tape_sdram_pkg::*;
#(
  parameter int AW           = TAPE_AW,
  parameter int FIFO_DEPTH   = TAPE_FIFO_DEPTH,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_full,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_busy,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack,
  input  logic          clear,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int WW = $clog2(STARVE_LIMIT) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  arb_state_t     state_r;
  logic [AW-1:0]  rd_addr_r;
  logic [WW-1:0]  wait_r;
  logic [TW-1:0]  wd_r;
  logic [AW+7:0]  head_s;
  logic           fifo_empty_s;
  logic           starve_s;
  logic           grant_rd_s;
  logic           pop_s;
  logic           wd_fire_s;
  logic           drop_s;

  byte_wr_fifo #(
    .W     (AW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_req),
    .pop   (pop_s),
    .din   ({wr_addr, wr_data}),
    .dout  (head_s),
    .full  (wr_full),
    .empty (fifo_empty_s)
  );

  // Arbitration decisions; a starving read outranks queued writes.
  always_comb begin
    starve_s   = rd_busy && (wait_r >= WW'(STARVE_LIMIT));
    grant_rd_s = (state_r == IDLE) && rd_busy && (starve_s || fifo_empty_s);
    pop_s      = (state_r == IDLE) && !fifo_empty_s && !starve_s;
    // wd_r counts edges already spent in the access; this edge is number wd_r+1.
    wd_fire_s  = (state_r != IDLE) && !mem_ack && (wd_r >= TW'(TIMEOUT - 1));
    drop_s     = wr_req && wr_full && !pop_s;
  end

  // Read wait counter: counts ungranted pending cycles, saturates, clears on grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_r <= {WW{1'b0}};
    end else if (grant_rd_s || !rd_busy) begin
      wait_r <= {WW{1'b0}};
    end else if ((state_r != READ) && (wait_r != {WW{1'b1}})) begin
      wait_r <= wait_r + WW'(1'b1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Sticky error flags; a new event in the same cycle as clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop_s)     overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
      else            overflow <= overflow;
      if (wd_fire_s)  timeout_err <= 1'b1;
      else if (clear) timeout_err <= 1'b0;
      else            timeout_err <= timeout_err;
    end
  end

  // Main FSM: issues one strobe per access, then waits for ack or watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      rd_addr_r <= {AW{1'b0}};
      rd_busy   <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_din   <= 8'h00;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      wd_r      <= {TW{1'b0}};
    end else begin
      mem_we   <= 1'b0;
      mem_rd   <= 1'b0;
      rd_valid <= 1'b0;
      // Only one read outstanding; requests while busy are dropped.
      if (rd_req && !rd_busy) begin
        rd_addr_r <= rd_addr;
        rd_busy   <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          wd_r <= {TW{1'b0}};
          if (grant_rd_s) begin
            mem_addr <= rd_addr_r;
            mem_rd   <= 1'b1;
            state_r  <= READ;
          end else if (pop_s) begin
            mem_addr <= head_s[AW+7:8];
            mem_din  <= head_s[7:0];
            mem_we   <= 1'b1;
            state_r  <= WRITE;
          end else begin
            state_r  <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ack || wd_fire_s) begin
            state_r <= IDLE;
          end else begin
            wd_r    <= wd_r + TW'(1'b1);
          end
        end
        READ: begin
          if (mem_ack) begin
            rd_data  <= mem_dout;
            rd_valid <= 1'b1;
            rd_busy  <= 1'b0;
            state_r  <= IDLE;
          end else if (wd_fire_s) begin
            rd_busy  <= 1'b0;
            state_r  <= IDLE;
          end else begin
            wd_r     <= wd_r + TW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
